// File: rtl/fec_dscr_xcode.sv
// ---------------------------------------------------------------------------
// fec_dscr_xcode
//
// Sits behind the FEC correction stage. Each corrected 65-bit transcoded
// block is converted back to a 66-bit block: the transcode bit becomes a
// 2-bit sync header, and the 64-bit payload is self-synchronously
// descrambled with x^58 + x^39 + 1. Control blocks whose descrambled
// block-type byte is not a legal type are counted and, optionally,
// replaced by an error block.
//
// Ports
//   CLK        in   block clock
//   RST        in   asynchronous active-high reset
//   FEC_LOCK   in   FEC lock status; low flushes descrambler state
//   C_BLK_ENA  in   corrected block valid (low on CRC / gap cycles)
//   C_BLK      in   [64] transcode bit (1 = data), [63:0] scrambled payload,
//                   bit 0 first in time
//   D_BLK_ENA  out  output block valid, one clock after the input block
//   D_BLK      out  [65:64] sync header, [63:0] descrambled payload;
//                   holds its last value while D_BLK_ENA is low
//   DSCR_SYNC  out  descrambler state primed (sync FSM in RUN)
//   CNT_CLR    in   single-cycle clear of ERR_CNT
//   ERR_CNT    out  saturating count of invalid control blocks
//
// Handshake: there is no back-pressure. A block is transferred on every
// clock where its ENA is high; ENA low means the data lines carry nothing.
// ---------------------------------------------------------------------------
module fec_dscr_xcode #(
    parameter bit DSCR_EN   = 1'b1,
    parameter bit ERR_SUBST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FEC_LOCK,
    input  logic             C_BLK_ENA,
    input  logic [64:0]      C_BLK,
    output logic             D_BLK_ENA,
    output logic [65:0]      D_BLK,
    output logic             DSCR_SYNC,
    input  logic             CNT_CLR,
    output logic [CNT_W-1:0] ERR_CNT
);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } sync_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [63:0]      ERR_BLK  = {{8{7'h1E}}, 8'h1E};

    sync_state_t      state_q, state_d;
    logic [57:0]      s_q, s_d;          // s_q[0] = most recent scrambled bit
    logic             ena_q, ena_d;
    logic [65:0]      blk_q, blk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [63:0]      tap39, tap58;
    logic [63:0]      dscr;
    logic [63:0]      payload;
    logic [63:0]      out_payload;
    logic [57:0]      s_next;
    logic [1:0]       header;
    logic             is_ctrl;
    logic             type_ok;
    logic             invalid;
    logic             emit;
    logic             cnt_inc;

    // Legal control block-type bytes.
    function automatic logic legal_type(input logic [7:0] t);
        case (t)
            8'h1E, 8'h2D, 8'h33, 8'h66, 8'h55, 8'h78, 8'h4B, 8'h87,
            8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: legal_type = 1'b1;
            default:                                         legal_type = 1'b0;
        endcase
    endfunction

    // Parallel form of the serial descrambler. Tap d bits back from bit i is
    // the stored state for i < d, otherwise an earlier bit of this block.
    always_comb begin
        tap39 = '0;
        tap58 = '0;
        for (int i = 0; i < 39; i++) tap39[i] = s_q[38-i];
        for (int i = 39; i < 64; i++) tap39[i] = C_BLK[i-39];
        for (int i = 0; i < 58; i++) tap58[i] = s_q[57-i];
        for (int i = 58; i < 64; i++) tap58[i] = C_BLK[i-58];
        dscr = C_BLK[63:0] ^ tap39 ^ tap58;

        // The last bit in time (bit 63) becomes the most recent state bit.
        s_next = '0;
        for (int k = 0; k < 58; k++) s_next[k] = C_BLK[63-k];
    end

    always_comb begin
        payload     = DSCR_EN ? dscr : C_BLK[63:0];
        is_ctrl     = ~C_BLK[64];
        header      = C_BLK[64] ? 2'b01 : 2'b10;
        type_ok     = legal_type(payload[7:0]);
        invalid     = is_ctrl & ~type_ok;
        out_payload = (invalid && ERR_SUBST) ? ERR_BLK : payload;
    end

    // Sync FSM and descrambler state update.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        emit    = 1'b0;
        if (!FEC_LOCK) begin
            state_d = ST_FLUSH;
            s_d     = '0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    s_d     = '0;
                    state_d = ST_PRIME;
                end
                ST_PRIME: begin
                    // First block only seeds the state; its output would be garbage.
                    if (C_BLK_ENA) begin
                        s_d     = s_next;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (C_BLK_ENA) begin
                        s_d  = s_next;
                        emit = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_FLUSH;
                    s_d     = '0;
                end
            endcase
        end
    end

    always_comb begin
        ena_d   = emit;
        blk_d   = emit ? {header, out_payload} : blk_q;
        cnt_inc = emit & invalid;
        cnt_d   = cnt_q;
        if (CNT_CLR) begin
            cnt_d = cnt_inc ? CNT_ONE : '0;
        end else if (cnt_inc && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_FLUSH;
            s_q     <= '0;
            ena_q   <= 1'b0;
            blk_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ena_q   <= ena_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
        end
    end

    assign D_BLK_ENA = ena_q;
    assign D_BLK     = blk_q;
    assign DSCR_SYNC = (state_q == ST_RUN);
    assign ERR_CNT   = cnt_q;

endmodule

// File: tb/tb_fec_dscr_xcode.sv
// ---------------------------------------------------------------------------
// tb_fec_dscr_xcode
//
// Directed bench for fec_dscr_xcode. Three instances share the stimulus:
// default parameters, ERR_SUBST=0, and CNT_W=4. Input payloads that must
// arrive scrambled are produced by a bit-serial reference scrambler.
// ---------------------------------------------------------------------------
module tb_fec_dscr_xcode;

    logic        CLK;
    logic        RST;
    logic        FEC_LOCK;
    logic        C_BLK_ENA;
    logic [64:0] C_BLK;
    logic        CNT_CLR;

    logic        a_ena, b_ena, c_ena;
    logic [65:0] a_blk, b_blk, c_blk;
    logic        a_sync, b_sync, c_sync;
    logic [15:0] a_cnt, b_cnt;
    logic [3:0]  c_cnt;

    int checks = 0;
    int errors = 0;

    logic [57:0] hist;    // reference scrambler history, hist[0] = newest

    localparam logic [65:0] IDLE_66 = {2'b10, 56'h0, 8'h1E};
    localparam logic [65:0] ERR_66  = {2'b10, {8{7'h1E}}, 8'h1E};

    fec_dscr_xcode u_dut (
        .CLK(CLK), .RST(RST), .FEC_LOCK(FEC_LOCK), .C_BLK_ENA(C_BLK_ENA),
        .C_BLK(C_BLK), .D_BLK_ENA(a_ena), .D_BLK(a_blk), .DSCR_SYNC(a_sync),
        .CNT_CLR(CNT_CLR), .ERR_CNT(a_cnt)
    );

    fec_dscr_xcode #(.ERR_SUBST(1'b0)) u_nosub (
        .CLK(CLK), .RST(RST), .FEC_LOCK(FEC_LOCK), .C_BLK_ENA(C_BLK_ENA),
        .C_BLK(C_BLK), .D_BLK_ENA(b_ena), .D_BLK(b_blk), .DSCR_SYNC(b_sync),
        .CNT_CLR(CNT_CLR), .ERR_CNT(b_cnt)
    );

    fec_dscr_xcode #(.CNT_W(4)) u_cnt4 (
        .CLK(CLK), .RST(RST), .FEC_LOCK(FEC_LOCK), .C_BLK_ENA(C_BLK_ENA),
        .C_BLK(C_BLK), .D_BLK_ENA(c_ena), .D_BLK(c_blk), .DSCR_SYNC(c_sync),
        .CNT_CLR(CNT_CLR), .ERR_CNT(c_cnt)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs applied just after a rising edge, outputs of that
    // block are visible on return (just after the following rising edge).
    task automatic drive(input logic ena, input logic [64:0] blk);
        C_BLK_ENA = ena;
        C_BLK     = blk;
        @(posedge CLK);
        #1;
    endtask

    // Reference scrambler: s = d ^ s(n-39) ^ s(n-58), bit 0 first.
    task automatic scramble(input logic [63:0] d, output logic [63:0] s);
        logic sb;
        for (int i = 0; i < 64; i++) begin
            sb   = d[i] ^ hist[38] ^ hist[57];
            hist = {hist[56:0], sb};
            s[i] = sb;
        end
    endtask

    task automatic send(input logic is_data, input logic [63:0] pl);
        logic [63:0] sv;
        scramble(pl, sv);
        drive(1'b1, {is_data, sv});
    endtask

    initial begin
        RST       = 1'b1;
        FEC_LOCK  = 1'b0;
        C_BLK_ENA = 1'b0;
        C_BLK     = '0;
        CNT_CLR   = 1'b0;
        hist      = '0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset state
        chk("rst_ena",  {65'h0, a_ena},  66'h0);
        chk("rst_blk",  a_blk,           66'h0);
        chk("rst_sync", {65'h0, a_sync}, 66'h0);
        chk("rst_cnt",  {50'h0, a_cnt},  66'h0);

        // Lock, then all-zero data blocks: first one primes and is dropped.
        RST      = 1'b0;
        FEC_LOCK = 1'b1;
        drive(1'b0, 65'h0);
        chk("flush_sync", {65'h0, a_sync}, 66'h0);
        drive(1'b1, {1'b1, 64'h0});
        chk("prime_drop", {65'h0, a_ena},  66'h0);
        chk("prime_sync", {65'h0, a_sync}, 66'h1);
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, {1'b1, 64'h0});
            chk("zero_ena", {65'h0, a_ena}, 66'h1);
            chk("zero_blk", a_blk, {2'b01, 64'h0});
        end

        // Lock drop for one cycle with a block in flight.
        FEC_LOCK = 1'b0;
        drive(1'b1, {1'b1, 64'h0});
        chk("unlock_ena",  {65'h0, a_ena},  66'h0);
        chk("unlock_sync", {65'h0, a_sync}, 66'h0);
        FEC_LOCK = 1'b1;
        drive(1'b0, 65'h0);
        chk("relock_sync", {65'h0, a_sync}, 66'h0);

        // Randomly seeded scrambled IDLE stream with periodic gaps.
        hist = {$urandom, $urandom} & 58'h3FF_FFFF_FFFF_FFFF;
        send(1'b0, 64'h1E);
        chk("idle_prime_drop", {65'h0, a_ena},  66'h0);
        chk("idle_prime_sync", {65'h0, a_sync}, 66'h1);
        for (int n = 0; n < 70; n++) begin
            if ((n % 33) == 32) begin
                drive(1'b0, C_BLK);
                chk("gap_ena",  {65'h0, a_ena},  66'h0);
                chk("gap_hold", a_blk,           IDLE_66);
                chk("gap_sync", {65'h0, a_sync}, 66'h1);
            end else begin
                send(1'b0, 64'h1E);
                chk("idle_ena", {65'h0, a_ena}, 66'h1);
                chk("idle_blk", a_blk,          IDLE_66);
            end
        end
        chk("idle_cnt", {50'h0, a_cnt}, 66'h0);

        // Invalid control type 00.
        send(1'b0, 64'h0);
        chk("inv_subst",     a_blk,          ERR_66);
        chk("inv_nosub_blk", b_blk,          {2'b10, 64'h0});
        chk("inv_cnt",       {50'h0, a_cnt}, 66'h1);
        chk("inv_nosub_cnt", {50'h0, b_cnt}, 66'h1);

        // Nonzero data and a legal control type pass through untouched.
        send(1'b1, 64'h0123_4567_89AB_CDEF);
        chk("data_blk", a_blk, {2'b01, 64'h0123_4567_89AB_CDEF});
        send(1'b0, 64'hDEAD_BEEF_0000_0078);
        chk("ctrl78_blk", a_blk,          {2'b10, 64'hDEAD_BEEF_0000_0078});
        chk("ctrl78_cnt", {50'h0, a_cnt}, 66'h1);

        // Nineteen more invalid blocks: 20 total.
        for (int n = 0; n < 14; n++) send(1'b0, 64'h0);
        chk("cnt4_at15", {62'h0, c_cnt}, 66'hF);
        for (int n = 0; n < 5; n++) send(1'b0, 64'h0);
        chk("cnt4_sat",  {62'h0, c_cnt}, 66'hF);
        chk("cnt16_20",  {50'h0, a_cnt}, 66'd20);
        chk("nosub_20",  {50'h0, b_cnt}, 66'd20);

        // Clear alone, then clear together with an increment.
        CNT_CLR = 1'b1;
        drive(1'b0, C_BLK);
        CNT_CLR = 1'b0;
        chk("clr_cnt4", {62'h0, c_cnt}, 66'h0);
        chk("clr_cnt",  {50'h0, a_cnt}, 66'h0);
        CNT_CLR = 1'b1;
        send(1'b0, 64'h0);
        CNT_CLR = 1'b0;
        chk("clrinc_cnt4", {62'h0, c_cnt}, 66'h1);
        chk("clrinc_cnt",  {50'h0, a_cnt}, 66'h1);
        chk("pre_rst_ena", {65'h0, a_ena}, 66'h1);

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2;
        RST = 1'b1;
        #1;
        chk("arst_ena",  {65'h0, a_ena},  66'h0);
        chk("arst_blk",  a_blk,           66'h0);
        chk("arst_sync", {65'h0, a_sync}, 66'h0);
        chk("arst_cnt",  {50'h0, a_cnt},  66'h0);
        chk("arst_cnt4", {62'h0, c_cnt},  66'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
